// File: rtl/hqc_rsdecod_roots.sv
// Chien-search root finder for the HQC Reed-Solomon decoder: evaluates sigma at alpha^-j for j=0..N1-1.
// Optional RSDEC_ROOT_FAIL_CHECK_EN adds the root-count vs. degree mismatch flag on fail_o.
module hqc_rsdecod_roots #(
  parameter int PARAM_SECURITY = 128,
  parameter int PARAM_DELTA    = (PARAM_SECURITY == 256) ? 29 : (PARAM_SECURITY == 192) ? 16 : 15,
  parameter int PARAM_N1       = (PARAM_SECURITY == 256) ? 90 : (PARAM_SECURITY == 192) ? 56 : 46,
  parameter int DIN_W          = 8 * (PARAM_DELTA + 1),
  parameter int DOUT_W         = PARAM_N1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DIN_W-1:0]  din_i,
  input  logic [7:0]        deg_sigma_i,
  input  logic              din_valid_i,
  output logic              busy_o,
  output logic [DOUT_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic [7:0]        err_cnt_o,
  output logic              fail_o
);

  localparam int NT = PARAM_DELTA + 1;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_xtime(r);
    return r;
  endfunction

  logic [NT-1:0][7:0] t;
  logic [NT-1:0][7:0] t_next;
  logic [7:0]         s;
  logic               hit;
  logic [6:0]         j;
  logic               last;
  logic               accept;
  logic               finish;
  logic [DOUT_W-1:0]  err_vec;
  logic [DOUT_W-1:0]  err_vec_next;
  logic [7:0]         cnt;
  logic [7:0]         cnt_next;

  // Term k advances by alpha^-k each cycle so that XOR of all terms walks sigma(alpha^-j).
  for (genvar k = 0; k < NT; k++) begin : g_term
    localparam logic [7:0] STEP = gf_alpha_pow((255 - k) % 255);
    assign t_next[k] = gf_mul(t[k], STEP);
  end

  always_comb begin
    s = 8'h00;
    for (int k = 0; k < NT; k++) s = s ^ t[k];
  end

  assign hit          = (s == 8'h00);
  assign last         = (j == 7'(PARAM_N1 - 1));
  assign accept       = din_valid_i & ~busy_o;
  assign finish       = busy_o & last;
  assign err_vec_next = err_vec | (hit ? (DOUT_W'(1) << j) : '0);
  assign cnt_next     = cnt + {7'd0, hit};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t            <= '0;
      j            <= '0;
      err_vec      <= '0;
      cnt          <= '0;
      busy_o       <= 1'b0;
      dout_valid_o <= 1'b0;
      dout_o       <= '0;
      err_cnt_o    <= '0;
    end else begin
      dout_valid_o <= 1'b0;
      if (accept) begin
        t       <= din_i;
        j       <= '0;
        err_vec <= '0;
        cnt     <= '0;
        busy_o  <= 1'b1;
      end else if (busy_o) begin
        t       <= t_next;
        j       <= j + 7'd1;
        err_vec <= err_vec_next;
        cnt     <= cnt_next;
        if (last) begin
          busy_o       <= 1'b0;
          dout_valid_o <= 1'b1;
          dout_o       <= err_vec_next;
          err_cnt_o    <= cnt_next;
        end
      end
    end
  end

`ifdef RSDEC_ROOT_FAIL_CHECK_EN
  logic [7:0] deg;
  logic       fail_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deg    <= '0;
      fail_q <= 1'b0;
    end else begin
      if (accept) deg <= deg_sigma_i;
      if (finish) fail_q <= (cnt_next != deg);
    end
  end

  assign fail_o = fail_q;
`else
  logic deg_unused;
  assign deg_unused = ^deg_sigma_i;
  assign fail_o     = 1'b0;
`endif

endmodule

// File: tb/tb_hqc_rsdecod_roots.sv
// Scoreboard bench for hqc_rsdecod_roots (security 128): log/exp-table Horner model predicts each result.
module tb_hqc_rsdecod_roots;

  localparam int DELTA  = 15;
  localparam int N1     = 46;
  localparam int DIN_W  = 8 * (DELTA + 1);
  localparam int DOUT_W = N1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIN_W-1:0]  din = '0;
  logic [7:0]        deg = '0;
  logic              din_valid = 1'b0;
  logic              busy;
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic [7:0]        err_cnt;
  logic              fail;

  hqc_rsdecod_roots #(.PARAM_SECURITY(128)) dut (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .deg_sigma_i(deg), .din_valid_i(din_valid),
    .busy_o(busy), .dout_o(dout), .dout_valid_o(dout_valid), .err_cnt_o(err_cnt), .fail_o(fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DOUT_W-1:0] vec;
    logic [7:0]        cnt;
    logic              fl;
    int                at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] gexp[0:255];
  int         glog[0:255];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic model(input logic [DIN_W-1:0] sg, input logic [7:0] dg, output exp_t e);
    logic [7:0] x, acc;
    e.vec = '0;
    e.cnt = '0;
    for (int jj = 0; jj < N1; jj++) begin
      x = gexp[(255 - jj) % 255];
      acc = 8'h00;
      for (int k = DELTA; k >= 0; k--) acc = gmul(acc, x) ^ sg[8*k +: 8];
      if (acc == 8'h00) begin
        e.vec[jj] = 1'b1;
        e.cnt = e.cnt + 8'd1;
      end
    end
`ifdef RSDEC_ROOT_FAIL_CHECK_EN
    e.fl = (e.cnt != dg);
`else
    e.fl = 1'b0;
`endif
    e.at = 0;
  endtask

  // Called at a negedge; drives the load in the first cycle the DUT is idle.
  task automatic load(input logic [DIN_W-1:0] sg, input logic [7:0] dg);
    exp_t e;
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("load_timeout", 64'(busy), 64'd0);
      return;
    end
    din = sg;
    deg = dg;
    din_valid = 1'b1;
    model(sg, dg, e);
    e.at = cyc + 1 + N1;
    sb.push_back(e);
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic load_roots(input int nroots);
    logic [7:0] p[0:DELTA];
    logic [DIN_W-1:0] sg;
    logic [63:0] used;
    int pos, d;
    for (int k = 0; k <= DELTA; k++) p[k] = 8'h00;
    p[0] = 8'h01;
    used = '0;
    d = 0;
    while (d < nroots) begin
      pos = $urandom_range(N1 - 1, 0);
      if (!used[pos]) begin
        used[pos] = 1'b1;
        d++;
        for (int k = d; k >= 1; k--) p[k] = p[k] ^ gmul(p[k-1], gexp[pos]);
      end
    end
    for (int k = 0; k <= DELTA; k++) sg[8*k +: 8] = p[k];
    load(sg, 8'(nroots));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dout_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("dout", 64'(dout), 64'(e.vec));
        chk("err_cnt", 64'(err_cnt), 64'(e.cnt));
        chk("fail", 64'(fail), 64'(e.fl));
        chk("latency", 64'(cyc), 64'(e.at));
        chk("busy_at_valid", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    int bc;
    logic [DIN_W-1:0] rs;
    gexp[0] = 8'h01;
    for (int i = 1; i < 256; i++)
      gexp[i] = {gexp[i-1][6:0], 1'b0} ^ (gexp[i-1][7] ? 8'h1D : 8'h00);
    for (int i = 0; i < 256; i++) glog[i] = 0;
    for (int i = 0; i < 255; i++) glog[gexp[i]] = i;

    #7;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_cnt", 64'(err_cnt), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // No errors; also measure the busy window.
    load(DIN_W'(8'h01), 8'd0);
    bc = 0;
    @(negedge clk);
    while (busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_len", 64'(bc), 64'(N1));
    drain();

    load(DIN_W'(16'h2001), 8'd1);
    load(DIN_W'(24'h080901), 8'd2);
    load(DIN_W'(16'hC101), 8'd1);
    load(DIN_W'(24'h010001), 8'd2);
    load('0, 8'd0);
    drain();

    // Stray strobe with different data at cycle 10 of a search.
    load(DIN_W'(16'h2001), 8'd1);
    repeat (10) @(negedge clk);
    din = DIN_W'(24'h080901);
    deg = 8'd2;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) load_roots(int'($urandom_range(DELTA, 0)));
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < DIN_W / 32; w++) rs[32*w +: 32] = $urandom;
      load(rs, 8'($urandom_range(DELTA, 0)));
    end
    drain();

    // Abort mid-search after a nonzero result is on the outputs.
    load(DIN_W'(16'h2001), 8'd1);
    drain();
    load(DIN_W'(24'h080901), 8'd2);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(dout_valid), 64'd0);
    chk("abort_dout", 64'(dout), 64'd0);
    chk("abort_cnt", 64'(err_cnt), 64'd0);
    chk("abort_fail", 64'(fail), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N1 + 5) begin
      @(negedge clk);
      chk("abort_quiet", 64'(dout_valid), 64'd0);
    end

    load(DIN_W'(16'hC101), 8'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
